conv1d_transpose: RTL and testbench
===================================

Name: conv1d_transpose

Overview:
- Single-multiplier 1-D transposed convolution (upsampling deconvolution) with AXI-style valid/ready streams on both sides.
- Each accepted input sample is scattered across FILTER_SIZE partial-sum accumulators. STRIDE completed outputs are then emitted, so the stream is upsampled by STRIDE.
- Sits in the decoder/upsampling path of the 1-D CNN, mirroring the forward conv stage. No activation inside; a downstream relu instance is used if needed.

Parameters:
- DATA_WIDTH, 12, width of data, weights, bias and outputs (two's complement).
- FILTER_SIZE, 5, number of kernel taps; must be >= STRIDE.
- STRIDE, 2, upsampling factor; outputs emitted per input sample; must be >= 1.
- FRACTION, 0, fractional bits of the fixed-point format.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, asynchronous assert, active-low (rst==0 resets).
- conv1d_transpose_ready_in  output  1  block can accept an input beat.
- conv1d_transpose_valid_in  input  1  input beat valid.
- conv1d_transpose_data_in  input  DATA_WIDTH  input sample x[n].
- conv1d_transpose_weights  input  DATA_WIDTH x [0:FILTER_SIZE-1]  static kernel w[k].
- conv1d_transpose_bias  input  DATA_WIDTH  static bias added to every output.
- conv1d_transpose_ready_out  input  1  downstream ready.
- conv1d_transpose_valid_out  output  1  output beat valid.
- conv1d_transpose_data_out  output  DATA_WIDTH  output sample y[m].

Behaviour:
- Function: y[m] = bias + sum over (n,k) with n*STRIDE+k == m of x[n]*w[k], starting at m=0 (causal, no leading padding).
- Accumulators: acc[0:FILTER_SIZE-1], each ACC_WIDTH = 2*DATA_WIDTH + clog2(FILTER_SIZE) signed. All accumulators are zero at reset.
- Signed multiply; full-width product, sign-extended into the accumulator; wrap-around, no saturation.
- Output truncation: data_out = acc[j][MSB -: DATA_WIDTH] + bias, with MSB = 2*DATA_WIDTH-1-(DATA_WIDTH-FRACTION). The addition wraps modulo 2^DATA_WIDTH.
- FSM states and transitions:
  - IDLE: ready_in=1. On valid_in&&ready_in, latch x into a register, set tap counter k=0, go to MAC.
  - MAC: one tap per cycle, acc[k] += x*w[k]. k counts 0..FILTER_SIZE-1. After the last tap, set emit counter j=0 and go to EMIT. Takes exactly FILTER_SIZE cycles; ready_in=0.
  - EMIT: present acc[j] result on data_out with valid_out=1 (registered output).
    - On valid_out&&ready_out, advance j.
    - After the STRIDE-th handshake: shift accumulators down by STRIDE (acc[i] <= acc[i+STRIDE], top STRIDE entries zeroed), go to IDLE.
    - data_out/valid_out hold stable while ready_out=0.
- Latency: the first output is valid FILTER_SIZE+1 cycles after the input handshake. Throughput is one input per FILTER_SIZE+STRIDE+1 cycles under no backpressure.
- ready_in is low in MAC and EMIT. An input offered then is not taken and must be held by upstream.
- valid_out is never asserted outside EMIT.
- Reset outputs: ready_in=0 while rst=0, then 1 (IDLE) from the first clock after release. valid_out=0, data_out=0, state=IDLE, counters=0.
- Reset mid-MAC or mid-EMIT: all state is discarded immediately (async), including pending partial sums.
- FILTER_SIZE==STRIDE: no overlap is carried; the shift zeros all accumulators.

Optional Feature:
- Macro: CONV1D_TRANSPOSE_FLUSH_EN.
- With the macro, adds input port conv1d_transpose_flush_in (1 bit), sampled only in IDLE; flush takes priority over valid_in in the same cycle.
  - On flush_in=1, enter EMIT for FILTER_SIZE-STRIDE beats, emitting the remaining tail partial sums acc[0..FILTER_SIZE-STRIDE-1] (+bias).
  - Then zero all accumulators and return to IDLE.
  - If FILTER_SIZE==STRIDE, flush is a no-op.
- Without the macro, the port does not exist and the tail is discarded only by reset.

Test Plan:
- Common config: DATA_WIDTH=12, FRACTION=0, FILTER_SIZE=3, STRIDE=2, w=[1,2,3], bias=0.
- Basic: inputs 1,2 with ready_out=1 -> outputs 1,2,5,4 in order. First valid_out exactly 4 cycles after the first input handshake.
- Bias/sign: bias=-1, input -2 -> outputs -3,-5.
- Backpressure: ready_out held 0 for 5 cycles in EMIT -> data_out/valid_out stable, ready_in=0 throughout, and no beat is lost or duplicated.
- Reset mid-MAC: rst=0 during the tap-1 cycle, then input 1 -> outputs 1,2 (no stale partial sums).
- Flush (CONV1D_TRANSPOSE_FLUSH_EN): inputs 1,2, then flush_in=1 in IDLE -> extra single output 6, then accumulators zero. A subsequent input 1 -> outputs 1,2.

Source files
------------

// File: rtl/conv1d_transpose.sv
// Single-multiplier 1-D transposed convolution: each input is scattered over FILTER_SIZE
// accumulators, then STRIDE finished outputs are streamed. Optional tail flush: CONV1D_TRANSPOSE_FLUSH_EN.
module conv1d_transpose #(
    parameter int DATA_WIDTH  = 12,
    parameter int FILTER_SIZE = 5,
    parameter int STRIDE      = 2,
    parameter int FRACTION    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         conv1d_transpose_ready_in,
    input  logic                         conv1d_transpose_valid_in,
    input  logic signed [DATA_WIDTH-1:0] conv1d_transpose_data_in,
    input  logic signed [DATA_WIDTH-1:0] conv1d_transpose_weights [0:FILTER_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0] conv1d_transpose_bias,
`ifdef CONV1D_TRANSPOSE_FLUSH_EN
    input  logic                         conv1d_transpose_flush_in,
`endif
    input  logic                         conv1d_transpose_ready_out,
    output logic                         conv1d_transpose_valid_out,
    output logic signed [DATA_WIDTH-1:0] conv1d_transpose_data_out
);
    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(FILTER_SIZE);
    localparam int MSB       = 2*DATA_WIDTH - 1 - (DATA_WIDTH - FRACTION);
    localparam int CW        = $clog2(FILTER_SIZE + 1);

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t                         state, state_nxt;
    logic signed [DATA_WIDTH-1:0]   x_q, x_nxt;
    logic [CW-1:0]                  k_q, k_nxt, j_q, j_nxt, last_j;
    logic                           flush_q, flush_nxt, flush_req;
    logic signed [ACC_WIDTH-1:0]    acc [FILTER_SIZE];
    logic signed [ACC_WIDTH-1:0]    acc_nxt [FILTER_SIZE];
    logic signed [ACC_WIDTH-1:0]    acc_sel;
    logic signed [DATA_WIDTH-1:0]   w_sel, data_nxt;
    logic signed [2*DATA_WIDTH-1:0] prod;

`ifdef CONV1D_TRANSPOSE_FLUSH_EN
    assign flush_req = conv1d_transpose_flush_in;
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        k_nxt     = k_q;
        j_nxt     = j_q;
        flush_nxt = flush_q;
        acc_nxt   = acc;
        w_sel     = conv1d_transpose_weights[0];
        for (int i = 0; i < FILTER_SIZE; i++)
            if (k_q == CW'(i)) w_sel = conv1d_transpose_weights[i];
        prod   = x_q * w_sel;
        last_j = flush_q ? CW'(FILTER_SIZE - STRIDE - 1) : CW'(STRIDE - 1);

        case (state)
            IDLE: begin
                if (conv1d_transpose_ready_in && flush_req) begin
                    // with no overlap there is no tail to drain
                    if (FILTER_SIZE > STRIDE) begin
                        state_nxt = EMIT;
                        j_nxt     = '0;
                        flush_nxt = 1'b1;
                    end
                end else if (conv1d_transpose_ready_in && conv1d_transpose_valid_in) begin
                    x_nxt     = conv1d_transpose_data_in;
                    k_nxt     = '0;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                for (int i = 0; i < FILTER_SIZE; i++)
                    if (k_q == CW'(i)) acc_nxt[i] = acc[i] + ACC_WIDTH'(prod);
                if (k_q == CW'(FILTER_SIZE - 1)) begin
                    state_nxt = EMIT;
                    j_nxt     = '0;
                end else begin
                    k_nxt = k_q + CW'(1);
                end
            end
            EMIT: begin
                if (conv1d_transpose_valid_out && conv1d_transpose_ready_out) begin
                    if (j_q == last_j) begin
                        for (int i = 0; i < FILTER_SIZE; i++) begin
                            if (!flush_q && i < FILTER_SIZE - STRIDE)
                                acc_nxt[i] = acc[(i + STRIDE) % FILTER_SIZE];
                            else
                                acc_nxt[i] = '0;
                        end
                        state_nxt = IDLE;
                        j_nxt     = '0;
                        flush_nxt = 1'b0;
                    end else begin
                        j_nxt = j_q + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // output register is loaded from next-cycle state so the first beat needs no bubble
        acc_sel = acc_nxt[0];
        for (int i = 0; i < FILTER_SIZE; i++)
            if (j_nxt == CW'(i)) acc_sel = acc_nxt[i];
        data_nxt = acc_sel[MSB -: DATA_WIDTH] + conv1d_transpose_bias;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                      <= IDLE;
            x_q                        <= '0;
            k_q                        <= '0;
            j_q                        <= '0;
            flush_q                    <= 1'b0;
            for (int i = 0; i < FILTER_SIZE; i++) acc[i] <= '0;
            conv1d_transpose_ready_in  <= 1'b0;
            conv1d_transpose_valid_out <= 1'b0;
            conv1d_transpose_data_out  <= '0;
        end else begin
            state                      <= state_nxt;
            x_q                        <= x_nxt;
            k_q                        <= k_nxt;
            j_q                        <= j_nxt;
            flush_q                    <= flush_nxt;
            acc                        <= acc_nxt;
            conv1d_transpose_ready_in  <= (state_nxt == IDLE);
            conv1d_transpose_valid_out <= (state_nxt == EMIT);
            conv1d_transpose_data_out  <= data_nxt;
        end
    end
endmodule

// File: tb/tb_conv1d_transpose.sv
// Directed bench for conv1d_transpose with FILTER_SIZE=3, STRIDE=2, w=[1,2,3].
module tb_conv1d_transpose;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready_in, valid_in, ready_out, valid_out;
    logic signed [DW-1:0] data_in, bias, data_out;
    logic signed [DW-1:0] w [0:2];
`ifdef CONV1D_TRANSPOSE_FLUSH_EN
    logic flush_in;
`endif

    int checks   = 0;
    int failures = 0;

    conv1d_transpose #(.DATA_WIDTH(DW), .FILTER_SIZE(3), .STRIDE(2), .FRACTION(0)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .conv1d_transpose_ready_in  (ready_in),
        .conv1d_transpose_valid_in  (valid_in),
        .conv1d_transpose_data_in   (data_in),
        .conv1d_transpose_weights   (w),
        .conv1d_transpose_bias      (bias),
`ifdef CONV1D_TRANSPOSE_FLUSH_EN
        .conv1d_transpose_flush_in  (flush_in),
`endif
        .conv1d_transpose_ready_out (ready_out),
        .conv1d_transpose_valid_out (valid_out),
        .conv1d_transpose_data_out  (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] b;
        int                   e0;
        int                   e1;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_ready_in", int'(ready_in), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'($signed(data_out)), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_in", int'(ready_in), 1);
    endtask

    // Offer one beat; optionally wait for the first output and report the cycle count.
    task automatic send(input logic signed [DW-1:0] x, input bit wait_out, output int lat);
        int n = 0;
        while (!ready_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_in", int'(ready_in), 1);
        valid_in = 1'b1;
        data_in  = x;
        @(negedge clk);
        valid_in = 1'b0;
        chk("mac_ready_in_low", int'(ready_in), 0);
        lat = 1;
        if (wait_out) begin
            while (!valid_out && lat < 100) begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic recv(input string name, input int exp);
        int n = 0;
        while (!valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, int'(valid_out), 1);
        chk(name, int'($signed(data_out)), exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tbl[0] = '{x:  1,    b: 0, e0: 1,     e1: 2};
        tbl[1] = '{x:  2,    b: 0, e0: 5,     e1: 4};
        tbl[2] = '{x: -1,    b: 0, e0: 5,     e1: -2};
        tbl[3] = '{x: 100,   b: 5, e0: 102,   e1: 205};
        tbl[4] = '{x: 2047,  b: 0, e0: -1749, e1: -2};
        tbl[5] = '{x:  0,    b: 0, e0: 2045,  e1: 0};

        w[0] = 12'sd1; w[1] = 12'sd2; w[2] = 12'sd3;
        bias = '0; valid_in = 1'b0; data_in = '0; ready_out = 1'b1;
`ifdef CONV1D_TRANSPOSE_FLUSH_EN
        flush_in = 1'b0;
`endif
        @(negedge clk);
        do_reset();

        // chained stream: overlap carried between entries, includes wrap cases
        for (int i = 0; i < 6; i++) begin
            bias = tbl[i].b;
            send(tbl[i].x, 1'b1, lat);
            if (i == 0) chk("first_latency", lat, 4);
            recv($sformatf("vec%0d_y0", i), tbl[i].e0);
            recv($sformatf("vec%0d_y1", i), tbl[i].e1);
            chk($sformatf("vec%0d_idle_valid", i), int'(valid_out), 0);
        end

        // bias and sign from clean state
        do_reset();
        bias = -12'sd1;
        send(-12'sd2, 1'b1, lat);
        recv("bias_y0", -3);
        recv("bias_y1", -5);
        bias = '0;

        // backpressure in EMIT
        do_reset();
        ready_out = 1'b0;
        send(12'sd3, 1'b1, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), int'(valid_out), 1);
            chk($sformatf("bp%0d_data", c), int'($signed(data_out)), 3);
            chk($sformatf("bp%0d_ready_in", c), int'(ready_in), 0);
        end
        ready_out = 1'b1;
        recv("bp_y0", 3);
        recv("bp_y1", 6);
        chk("bp_no_dup_valid", int'(valid_out), 0);
        chk("bp_ready_in", int'(ready_in), 1);

        // reset during tap 1 drops the partial sums of the abandoned input
        do_reset();
        send(12'sd5, 1'b0, lat);
        @(negedge clk);
        do_reset();
        send(12'sd1, 1'b1, lat);
        recv("rstmac_y0", 1);
        recv("rstmac_y1", 2);

`ifdef CONV1D_TRANSPOSE_FLUSH_EN
        do_reset();
        send(12'sd1, 1'b1, lat);
        recv("fl_a0", 1);
        recv("fl_a1", 2);
        send(12'sd2, 1'b1, lat);
        recv("fl_b0", 5);
        recv("fl_b1", 4);
        chk("fl_ready_before", int'(ready_in), 1);
        flush_in = 1'b1;
        valid_in = 1'b1;
        data_in  = 12'sd7;
        @(negedge clk);
        flush_in = 1'b0;
        valid_in = 1'b0;
        recv("fl_tail", 6);
        chk("fl_done_valid", int'(valid_out), 0);
        send(12'sd1, 1'b1, lat);
        recv("fl_c0", 1);
        recv("fl_c1", 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
